fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_skid_buf.sv | 52 +++++
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HOLD
    } fetch_state_t;

    localparam int ADDR_W_DEF  = 8;
    localparam int XLEN_DEF    = 32;
    localparam int PC_STEP_DEF = 4;
    localparam int STEP_LSB    = $clog2(PC_STEP_DEF);

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [XLEN_DEF-1:0]   instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: control inputs, instruction-memory port and decode handshake.
interface fetch_unit_if #(
    parameter int ADDR_W = 8,
    parameter int XLEN   = 32
);
    logic              hold_i;
    logic              redirect_valid_i;
    logic [ADDR_W-1:0] redirect_pc_i;
    logic              imem_req_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [XLEN-1:0]   imem_rdata_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [ADDR_W-1:0] out_pc_o;
    logic [XLEN-1:0]   out_instr_o;
    logic              misalign_o;

    modport master (
        output hold_i, redirect_valid_i, redirect_pc_i, imem_rdata_i, out_ready_i,
        input  imem_req_o, imem_addr_o, out_valid_o, out_pc_o, out_instr_o, misalign_o
    );

    modport slave (
        input  hold_i, redirect_valid_i, redirect_pc_i, imem_rdata_i, out_ready_i,
        output imem_req_o, imem_addr_o, out_valid_o, out_pc_o, out_instr_o, misalign_o
    );
endinterface

// File: rtl/fetch_skid_buf.sv
// Small circular FIFO holding fetched {pc, instr} entries until decode takes them.
module fetch_skid_buf #(
    parameter  int WIDTH = 40,
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;
    logic             do_push;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Program-counter front end: issues fetches, captures responses, hands them to decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              ADDR_W    = 8,
    parameter int              XLEN      = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int              PC_STEP   = 4,
    parameter int              BUF_DEPTH = 2
) (
    input logic         clk,
    input logic         rst,
    fetch_unit_if.slave bus
);
    localparam logic [ADDR_W-1:0] STEP_MASK = ADDR_W'(PC_STEP - 1);
    localparam int                CNT_W     = $clog2(BUF_DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [XLEN-1:0]   instr;
    } entry_t;

    fetch_state_t      state;
    fetch_state_t      next_state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc;
    logic              inflight;
    logic              misalign;
    logic              req;
    logic              credit;
    logic              pop;
    logic              push;
    logic [CNT_W-1:0]  count;
    entry_t            head;
    entry_t            push_entry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_BOOT;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_BOOT:  next_state = S_RUN;
            S_RUN:   if (bus.hold_i)  next_state = S_HOLD;
            S_HOLD:  if (!bus.hold_i) next_state = S_RUN;
            default: next_state = S_BOOT;
        endcase
    end

    // Credit counts the in-flight response as already occupying a slot, so a
    // full buffer can never be overrun by a late memory return.
    always_comb begin
        pop    = bus.out_valid_o && bus.out_ready_i;
        credit = (int'(count) + int'(inflight) - int'(pop)) < BUF_DEPTH;
        req    = (state == S_RUN) && !bus.hold_i && !bus.redirect_valid_i && credit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_VEC;
            req_pc   <= '0;
            inflight <= 1'b0;
            misalign <= 1'b0;
        end else begin
            inflight <= req;
            misalign <= bus.redirect_valid_i && ((bus.redirect_pc_i & STEP_MASK) != '0);
            if (bus.redirect_valid_i) begin
                pc <= bus.redirect_pc_i & ~STEP_MASK;
            end else if (req) begin
                req_pc <= pc;
                pc     <= pc + ADDR_W'(PC_STEP);
            end
        end
    end

    assign push             = inflight && !bus.redirect_valid_i;
    assign push_entry.pc    = req_pc;
    assign push_entry.instr = bus.imem_rdata_i;

    fetch_skid_buf #(
        .WIDTH(ADDR_W + XLEN),
        .DEPTH(BUF_DEPTH)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_entry),
        .pop      (pop),
        .flush    (bus.redirect_valid_i),
        .count    (count),
        .head     (head)
    );

    assign bus.imem_req_o  = req;
    assign bus.imem_addr_o = pc;
    assign bus.out_valid_o = (count != '0);
    assign bus.out_pc_o    = head.pc;
    assign bus.out_instr_o = head.instr;
    assign bus.misalign_o  = misalign;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int          ADDR_W    = 8;
    localparam int          XLEN      = 32;
    localparam int          PC_STEP   = 4;
    localparam int          DEPTH     = 2;
    localparam logic [7:0]  RESET_VEC = 8'h00;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(ADDR_W), .XLEN(XLEN)) bus ();

    fetch_unit #(
        .ADDR_W   (ADDR_W),
        .XLEN     (XLEN),
        .RESET_VEC(RESET_VEC),
        .PC_STEP  (PC_STEP),
        .BUF_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [XLEN-1:0] mem [256];
    logic [XLEN-1:0] rdata_q;

    always @(posedge clk) begin
        if (bus.imem_req_o) rdata_q <= mem[bus.imem_addr_o];
    end
    assign bus.imem_rdata_i = rdata_q;

    int errors = 0;
    int checks = 0;

    fetch_entry_t m_q[$];
    logic [7:0]   m_pc;
    logic [7:0]   m_infl_pc;
    bit           m_infl;
    bit           m_boot;
    bit           m_hold;
    bit           m_mis;
    bit           m_pop;
    bit           m_req;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc      = RESET_VEC;
        m_infl_pc = '0;
        m_infl    = 0;
        m_boot    = 1;
        m_hold    = 0;
        m_mis     = 0;
    endtask

    task automatic model_update();
        fetch_entry_t e;
        if (bus.redirect_valid_i) begin
            m_mis = (bus.redirect_pc_i % PC_STEP) != 0;
            m_pc  = bus.redirect_pc_i - 8'(bus.redirect_pc_i % PC_STEP);
            m_q.delete();
            m_infl = 0;
        end else begin
            m_mis = 0;
            if (m_pop) void'(m_q.pop_front());
            if (m_infl) begin
                e.pc    = m_infl_pc;
                e.instr = mem[m_infl_pc];
                m_q.push_back(e);
            end
            m_infl = m_req;
            if (m_req) begin
                m_infl_pc = m_pc;
                m_pc      = 8'(m_pc + PC_STEP);
            end
        end
        m_hold = !m_boot && bus.hold_i;
        m_boot = 0;
    endtask

    task automatic cycle();
        @(negedge clk);
        if (rst) model_reset();
        m_pop = (m_q.size() > 0) && bus.out_ready_i;
        m_req = !m_boot && !m_hold && !bus.hold_i && !bus.redirect_valid_i &&
                ((m_q.size() + int'(m_infl) - int'(m_pop)) < DEPTH);
        chk("imem_req", bus.imem_req_o, m_req);
        chk("imem_addr", bus.imem_addr_o, m_pc);
        chk("out_valid", bus.out_valid_o, m_q.size() > 0);
        if (m_q.size() > 0) begin
            chk("out_pc", bus.out_pc_o, m_q[0].pc);
            chk("out_instr", bus.out_instr_o, m_q[0].instr);
        end
        chk("misalign", bus.misalign_o, m_mis);
        @(posedge clk);
        if (!rst) model_update();
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic redirect(input logic [7:0] tgt);
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i    = tgt;
        cycle();
        bus.redirect_valid_i = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        rst                  = 1'b1;
        bus.hold_i           = 1'b0;
        bus.redirect_valid_i = 1'b0;
        bus.redirect_pc_i    = '0;
        bus.out_ready_i      = 1'b1;
        model_reset();

        // reset, boot cycle and steady streaming
        run(3);
        rst = 1'b0;
        run(10);

        // hold for five cycles mid-stream
        bus.hold_i = 1'b1;
        run(5);
        bus.hold_i = 1'b0;
        run(8);

        // decode stall for six cycles
        bus.out_ready_i = 1'b0;
        run(6);
        bus.out_ready_i = 1'b1;
        run(6);

        // redirect with a response in flight and buffered entries
        bus.out_ready_i = 1'b0;
        run(1);
        redirect(8'h40);
        bus.out_ready_i = 1'b1;
        chk("addr_after_redirect", bus.imem_addr_o, 8'h40);
        run(8);

        // misaligned target
        redirect(8'h42);
        run(6);

        // wrap around the top of the address space
        redirect(8'hF8);
        run(8);

        // redirect together with hold
        bus.hold_i = 1'b1;
        redirect(8'h10);
        run(3);
        bus.hold_i = 1'b0;
        run(5);

        // randomized traffic
        for (int i = 0; i < 120; i++) begin
            bus.hold_i           = ($urandom_range(0, 3) == 0);
            bus.out_ready_i      = ($urandom_range(0, 3) != 0);
            bus.redirect_valid_i = ($urandom_range(0, 15) == 0);
            bus.redirect_pc_i    = 8'($urandom);
            cycle();
        end
        bus.hold_i           = 1'b0;
        bus.redirect_valid_i = 1'b0;
        bus.out_ready_i      = 1'b1;
        run(6);

        // asynchronous reset in the middle of streaming
        chk("pre_reset_valid", bus.out_valid_o, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_out_valid", bus.out_valid_o, 1'b0);
        chk("async_imem_req", bus.imem_req_o, 1'b0);
        chk("async_pc", bus.imem_addr_o, RESET_VEC);
        model_reset();
        run(2);
        rst = 1'b0;
        run(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
